// File: rtl/rfphoenix_vec_wb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// rfphoenix_vec_wb_arbiter_pkg : shared types for the vector writeback arbiter
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package rfphoenix_vec_wb_arbiter_pkg;

  localparam int NLANES  = 16;
  localparam int WB_NSRC = 3;

  typedef logic [3:0] tid_t;

  typedef struct packed {
    logic [5:0] num;
  } regspec_t;

  typedef logic [NLANES-1:0][31:0] vector_value_t;

  typedef struct packed {
    tid_t          thread;
    regspec_t      rg;
    logic [63:0]   mask;
    vector_value_t res;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SRC_ALU = 2'd0,
    SRC_FPU = 2'd1,
    SRC_MEM = 2'd2
  } src_t;

  // Round-robin successor over the three producers.
  function automatic src_t rr_next(input src_t s);
    case (s)
      SRC_ALU: return SRC_FPU;
      SRC_FPU: return SRC_MEM;
      default: return SRC_ALU;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/rfphoenix_vec_wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// rfphoenix_vec_wb_arbiter_if : one producer's result channel into the arbiter
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface rfphoenix_vec_wb_arbiter_if;
  import rfphoenix_vec_wb_arbiter_pkg::*;

  logic          v;
  logic          rdy;
  tid_t          thread;
  regspec_t      rg;
  vector_value_t res;
  logic [63:0]   mask;

  modport master (output v, thread, rg, res, mask, input rdy);
  modport slave  (input v, thread, rg, res, mask, output rdy);

endinterface

`default_nettype wire

// File: rtl/rfphoenix_vec_wb_arbiter_fifo.sv
// ---------------------------------------------------------------------------
// rfPhoenix_wb_fifo : synchronous FIFO of writeback entries
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rfPhoenix_wb_fifo
  import rfphoenix_vec_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  wb_entry_t     din_i,
  output wb_entry_t     dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  wb_entry_t       mem_q [DEPTH];
  logic [AW-1:0]   wptr_q;
  logic [AW-1:0]   rptr_q;
  logic [CW-1:0]   count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + PTR_ONE;
      if (pop_i)  rptr_q <= rptr_q + PTR_ONE;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rptr_q];
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/rfphoenix_vec_wb_arbiter.sv
// ---------------------------------------------------------------------------
// rfphoenix_vec_wb_arbiter : round-robin writeback arbiter for the VRF port
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rfphoenix_vec_wb_arbiter
  import rfphoenix_vec_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             ce_i,
  rfphoenix_vec_wb_arbiter_if.slave        alu,
  rfphoenix_vec_wb_arbiter_if.slave        fpu,
  rfphoenix_vec_wb_arbiter_if.slave        mem,
  output logic                             wr_o,
  output tid_t                             wthread_o,
  output regspec_t                         wa_o,
  output logic [63:0]                      wmask_o,
  output vector_value_t                    i_o,
  output logic                             busy_o
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [WB_NSRC-1:0] src_v, src_rdy, push, pop, full, empty;
  wb_entry_t          din   [WB_NSRC];
  wb_entry_t          dout  [WB_NSRC];
  logic [CW-1:0]      count [WB_NSRC];

  assign src_v  = {mem.v, fpu.v, alu.v};
  assign din[0] = '{thread: alu.thread, rg: alu.rg, mask: alu.mask, res: alu.res};
  assign din[1] = '{thread: fpu.thread, rg: fpu.rg, mask: fpu.mask, res: fpu.res};
  assign din[2] = '{thread: mem.thread, rg: mem.rg, mask: mem.mask, res: mem.res};

  // Ready depends only on registered fullness, ce and rst, never on src_v.
  assign src_rdy = {WB_NSRC{ce_i & ~rst}} & ~full;
  assign push    = src_v & src_rdy;
  assign alu.rdy = src_rdy[0];
  assign fpu.rdy = src_rdy[1];
  assign mem.rdy = src_rdy[2];

  for (genvar g = 0; g < WB_NSRC; g++) begin : g_src
    rfPhoenix_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push[g]),
      .pop_i   (pop[g]),
      .din_i   (din[g]),
      .dout_o  (dout[g]),
      .full_o  (full[g]),
      .empty_o (empty[g]),
      .count_o (count[g])
    );
  end

  src_t last_q, last_d;
  src_t win, cand;
  logic found;

  always_comb begin
    found = 1'b0;
    win   = last_q;
    cand  = rr_next(last_q);
    for (int k = 0; k < WB_NSRC; k++) begin
      if (!found && !empty[cand]) begin
        found = 1'b1;
        win   = cand;
      end
      cand = rr_next(cand);
    end
  end

  assign pop = (ce_i && !rst && found) ? (WB_NSRC'(1) << win) : '0;

  wb_entry_t     sel;
  logic          wr_q, wr_d;
  tid_t          wthread_q, wthread_d;
  regspec_t      wa_q, wa_d;
  logic [63:0]   wmask_q, wmask_d;
  vector_value_t i_q, i_d;

  assign sel = dout[win];

  // Zero-mask entries still load the output registers but never strobe wr.
  always_comb begin
    last_d    = last_q;
    wr_d      = wr_q;
    wthread_d = wthread_q;
    wa_d      = wa_q;
    wmask_d   = wmask_q;
    i_d       = i_q;
    if (ce_i) begin
      wr_d = 1'b0;
      if (found) begin
        wr_d      = |sel.mask;
        wthread_d = sel.thread;
        wa_d      = sel.rg;
        wmask_d   = sel.mask;
        i_d       = sel.res;
        last_d    = win;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q    <= SRC_MEM;
      wr_q      <= 1'b0;
      wthread_q <= '0;
      wa_q      <= '0;
      wmask_q   <= '0;
      i_q       <= '0;
    end else begin
      last_q    <= last_d;
      wr_q      <= wr_d;
      wthread_q <= wthread_d;
      wa_q      <= wa_d;
      wmask_q   <= wmask_d;
      i_q       <= i_d;
    end
  end

  logic pending;
  always_comb begin
    pending = 1'b0;
    for (int k = 0; k < WB_NSRC; k++) pending = pending | (count[k] != '0);
  end

  assign wr_o      = wr_q;
  assign wthread_o = wthread_q;
  assign wa_o      = wa_q;
  assign wmask_o   = wmask_q;
  assign i_o       = i_q;
  assign busy_o    = wr_q | pending;

endmodule

`default_nettype wire
